// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating ICache word fetches and LSB loads/stores.
// Reads stream one address per cycle; flags and data are registered one-cycle pulses.
module mem_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rdy,
  input  logic [7:0]  i_mem_din,
  output logic [7:0]  o_mem_dout,
  output logic [31:0] o_mem_a,
  output logic        o_mem_wr,
  input  logic        i_io_buffer_full,
  input  logic        i_jp_wrong,
  input  logic        i_ic_req,
  input  logic [31:0] i_ic_addr,
  output logic        o_ic_flag,
  output logic [31:0] o_ic_data,
  input  logic        i_lsb_req,
  input  logic        i_lsb_wr,
  input  logic [1:0]  i_lsb_len,
  input  logic [31:0] i_lsb_addr,
  input  logic [31:0] i_lsb_wdata,
  output logic        o_lsb_flag,
  output logic [31:0] o_lsb_rdata
);

  typedef enum logic [1:0] {StIdle, StIcRead, StLsRead, StLsWrite} state_e;
  localparam logic GrantIc  = 1'b0;
  localparam logic GrantLsb = 1'b1;

  state_e      r_state, w_state_next;
  logic [2:0]  r_cnt;
  logic [1:0]  r_last;
  logic [31:0] r_addr, r_wdata, r_data;
  logic        r_last_grant, r_ic_flag, r_lsb_flag, r_lsb_flag_rd;
  logic [31:0] r_ic_data, r_lsb_rdata;
  logic        r_rdy_prev;
  logic [7:0]  r_din_hold;

  logic        w_idle, w_reading, w_accept, w_grant_lsb, w_stall, w_rd_done, w_wr_done;
  logic [1:0]  w_lsb_last;
  logic [31:0] w_cur_a, w_rd_data;
  logic [7:0]  w_din;

  assign w_idle      = (r_state == StIdle);
  assign w_reading   = (r_state == StIcRead) || (r_state == StLsRead);
  assign w_accept    = w_idle && i_rdy && !i_jp_wrong && !r_ic_flag && !r_lsb_flag &&
                       (i_ic_req || i_lsb_req);
  assign w_grant_lsb = i_lsb_req && (!i_ic_req || (r_last_grant == GrantIc));
  assign w_lsb_last  = (i_lsb_len == 2'b00) ? 2'd0 : (i_lsb_len == 2'b01) ? 2'd1 : 2'd3;
  assign w_cur_a     = r_addr + {29'd0, r_cnt};
  assign w_stall     = (r_state == StLsWrite) && (w_cur_a[17:16] == 2'b11) && i_io_buffer_full;
  assign w_rd_done   = w_reading && (r_cnt == ({1'b0, r_last} + 3'd1));
  assign w_wr_done   = (r_state == StLsWrite) && !w_stall && (r_cnt == {1'b0, r_last});

  // The RAM keeps running while rdy is low, so the byte answering the last active address
  // is parked in r_din_hold and replayed on the first active cycle.
  assign w_din = r_rdy_prev ? i_mem_din : r_din_hold;

  always_comb begin
    w_rd_data = r_data;
    for (int i = 0; i < 4; i++) begin
      if (r_cnt == 3'(i + 1)) w_rd_data[8*i +: 8] = w_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_state <= StIdle;
    else if (i_rdy) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = w_grant_lsb ? (i_lsb_wr ? StLsWrite : StLsRead) : StIcRead;
        end
      end
      StIcRead, StLsRead: if (i_jp_wrong || w_rd_done) w_state_next = StIdle;
      StLsWrite:          if (w_wr_done) w_state_next = StIdle;
      default:            w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_mem_a    = 32'd0;
    o_mem_dout = 8'd0;
    o_mem_wr   = 1'b0;
    if (!w_idle) o_mem_a = w_cur_a;
    if (r_state == StLsWrite) begin
      o_mem_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
      o_mem_wr   = i_rdy && !w_stall;
    end
    o_ic_flag  = r_ic_flag && i_rdy && !i_jp_wrong;
    o_lsb_flag = r_lsb_flag && i_rdy && !(i_jp_wrong && r_lsb_flag_rd);
  end

  assign o_ic_data   = r_ic_data;
  assign o_lsb_rdata = r_lsb_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt         <= 3'd0;
      r_last        <= 2'd0;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_data        <= 32'd0;
      r_last_grant  <= GrantIc;
      r_ic_flag     <= 1'b0;
      r_lsb_flag    <= 1'b0;
      r_lsb_flag_rd <= 1'b0;
      r_ic_data     <= 32'd0;
      r_lsb_rdata   <= 32'd0;
    end else if (i_rdy) begin
      r_ic_flag  <= 1'b0;
      r_lsb_flag <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_cnt        <= 3'd0;
            r_data       <= 32'd0;
            r_last_grant <= w_grant_lsb ? GrantLsb : GrantIc;
            r_addr       <= w_grant_lsb ? i_lsb_addr : i_ic_addr;
            r_last       <= w_grant_lsb ? w_lsb_last : 2'd3;
            r_wdata      <= i_lsb_wdata;
          end
        end
        StIcRead, StLsRead: begin
          if (i_jp_wrong) begin
            r_cnt <= 3'd0;
          end else if (w_rd_done) begin
            r_cnt <= 3'd0;
            if (r_state == StIcRead) begin
              r_ic_flag <= 1'b1;
              r_ic_data <= w_rd_data;
            end else begin
              r_lsb_flag    <= 1'b1;
              r_lsb_flag_rd <= 1'b1;
              r_lsb_rdata   <= w_rd_data;
            end
          end else begin
            r_data <= w_rd_data;
            r_cnt  <= r_cnt + 3'd1;
          end
        end
        StLsWrite: begin
          if (w_wr_done) begin
            r_cnt         <= 3'd0;
            r_lsb_flag    <= 1'b1;
            r_lsb_flag_rd <= 1'b0;
          end else if (!w_stall) begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: r_cnt <= 3'd0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdy_prev <= 1'b0;
      r_din_hold <= 8'd0;
    end else begin
      r_rdy_prev <= i_rdy;
      if (r_rdy_prev && !i_rdy) r_din_hold <= i_mem_din;
    end
  end

endmodule
